// File: rtl/tx_engine_pkg.sv
// Shared UART definitions for the transmit engine: frame geometry, FSM
// encodings, B8/B9 selection constants and parity/selection helpers.
package tx_engine_pkg;

   localparam int unsigned FRAME_LEN = 11;
   localparam int unsigned K_WIDTH   = 20;
   localparam logic [3:0]  LAST_BIT  = 4'(FRAME_LEN - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } tx_state_e;

   typedef enum logic [1:0] {
      BSEL_D7  = 2'd0,
      BSEL_PAR = 2'd1,
      BSEL_ONE = 2'd2
   } bsel_e;

   // Parity over the data bits in use; odd sense inverts the plain XOR.
   function automatic logic parity_bit(input logic [7:0] data, input logic eight,
                                       input logic odd);
      logic [7:0] mask;
      mask = eight ? 8'hFF : 8'h7F;
      return (^(data & mask)) ^ odd;
   endfunction

   function automatic bsel_e b8_sel(input logic eight, input logic pen);
      case ({eight, pen})
         2'b11:   return BSEL_D7;
         2'b10:   return BSEL_D7;
         2'b01:   return BSEL_PAR;
         default: return BSEL_ONE;
      endcase
   endfunction

   function automatic bsel_e b9_sel(input logic eight, input logic pen);
      case ({eight, pen})
         2'b11:   return BSEL_PAR;
         default: return BSEL_ONE;
      endcase
   endfunction

   function automatic logic bsel_pick(input bsel_e sel, input logic d7, input logic par);
      case (sel)
         BSEL_D7:  return d7;
         BSEL_PAR: return par;
         default:  return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/tx_engine_if.sv
// Host-side handshake and serial output bundle for tx_engine.
interface tx_engine_if;
   import tx_engine_pkg::*;

   logic                 LOAD;
   logic [7:0]           OUT_PORT;
   logic                 EIGHT;
   logic                 PEN;
   logic                 OHEL;
   logic [K_WIDTH-1:0]   K;
   logic                 TX;
   logic                 TXRDY;

   modport master (
      output LOAD, OUT_PORT, EIGHT, PEN, OHEL, K,
      input  TX, TXRDY
   );

   modport slave (
      input  LOAD, OUT_PORT, EIGHT, PEN, OHEL, K,
      output TX, TXRDY
   );

endinterface

// File: rtl/tx_engine_baud_tick.sv
// Bit-time generator: counts 0..K-1 while enabled and emits a one-cycle
// tick on the last count; held at zero while disabled.
module baud_tick
   import tx_engine_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [K_WIDTH-1:0] K,
   output logic               tick
);

   logic [K_WIDTH-1:0] cnt_q;
   logic [K_WIDTH-1:0] cnt_d;

   // Next count and terminal-count tick.
   always_comb begin
      tick  = 1'b0;
      cnt_d = cnt_q;
      if (!en) begin
         cnt_d = '0;
      end else if (cnt_q == (K - 20'd1)) begin
         tick  = 1'b1;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 20'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tx_engine.sv
// UART transmit engine: latches a byte plus framing options on LOAD and
// shifts out a fixed 11-bit frame, each bit held for K clocks.
module tx_engine
   import tx_engine_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   tx_engine_if.slave  bus
);

   tx_state_e                state_q, state_d;
   logic                     tx_q, tx_d;
   logic                     rdy_q, rdy_d;
   logic [FRAME_LEN-2:0]     shreg_q, shreg_d;
   logic [3:0]               bit_cnt_q, bit_cnt_d;
   logic [K_WIDTH-1:0]       k_q, k_d;
   logic [FRAME_LEN-1:0]     frame_s;
   logic                     par_s;
   logic                     tick_s;
   logic                     shift_en_s;

   // Frame assembled from the live inputs; only captured on the accept edge.
   always_comb begin
      par_s   = parity_bit(bus.OUT_PORT, bus.EIGHT, bus.OHEL);
      frame_s = {1'b1,
                 bsel_pick(b9_sel(bus.EIGHT, bus.PEN), bus.OUT_PORT[7], par_s),
                 bsel_pick(b8_sel(bus.EIGHT, bus.PEN), bus.OUT_PORT[7], par_s),
                 bus.OUT_PORT[6:0],
                 1'b0};
   end

   assign shift_en_s = (state_q == ST_SHIFT);

   baud_tick u_baud_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (shift_en_s),
      .K    (k_q),
      .tick (tick_s)
   );

   // FSM next state: start bit goes out on the accept edge, later bits on ticks.
   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      rdy_d     = rdy_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      k_d       = k_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.LOAD) begin
               state_d   = ST_SHIFT;
               tx_d      = frame_s[0];
               rdy_d     = 1'b0;
               shreg_d   = frame_s[FRAME_LEN-1:1];
               bit_cnt_d = 4'd0;
               k_d       = (bus.K == 20'd0) ? 20'd1 : bus.K;
            end else begin
               tx_d  = 1'b1;
               rdy_d = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (tick_s && (bit_cnt_q == LAST_BIT)) begin
               state_d = ST_IDLE;
               tx_d    = 1'b1;
               rdy_d   = 1'b1;
            end else if (tick_s) begin
               bit_cnt_d = bit_cnt_q + 4'd1;
               tx_d      = shreg_q[0];
               shreg_d   = {1'b1, shreg_q[FRAME_LEN-2:1]};
            end else begin
               tx_d = tx_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            rdy_d   = 1'b1;
         end
      endcase
   end

   // State and registered outputs; reset forces the line idle immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         tx_q      <= 1'b1;
         rdy_q     <= 1'b1;
         shreg_q   <= '0;
         bit_cnt_q <= 4'd0;
         k_q       <= '0;
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         rdy_q     <= rdy_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         k_q       <= k_d;
      end
   end

   assign bus.TX    = tx_q;
   assign bus.TXRDY = rdy_q;

endmodule

// File: tb/tb_tx_engine.sv
// Scoreboard bench for tx_engine: stimulus queues expected frames, a
// negedge monitor captures each TXRDY-low window and compares it.
module tb_tx_engine;

   typedef struct {
      logic [10:0] bits;
      int          k;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   int          ntests = 0;
   int          nfail  = 0;
   exp_t        exp_q[$];
   bit          in_frame = 1'b0;
   bit          smp[$];

   tx_engine_if bus ();

   tx_engine dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input longint act, input longint exp);
      ntests++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference frame built bit by bit from the framing rules.
   function automatic logic [10:0] model_frame(input logic [7:0] d, input bit eight,
                                               input bit pen, input bit ohel);
      bit          q[$];
      int          nbits;
      int          ones;
      bit          par;
      logic [10:0] f;
      nbits = eight ? 8 : 7;
      ones  = 0;
      for (int i = 0; i < nbits; i++) if (d[i]) ones++;
      par = ((ones % 2) == 1) ^ ohel;
      q.push_back(1'b0);
      for (int i = 0; i < 7; i++) q.push_back(d[i]);
      if (eight) begin
         q.push_back(d[7]);
         q.push_back(pen ? par : 1'b1);
      end else begin
         q.push_back(pen ? par : 1'b1);
         q.push_back(1'b1);
      end
      q.push_back(1'b1);
      for (int i = 0; i < 11; i++) f[i] = q[i];
      return f;
   endfunction

   function automatic void check_frame();
      exp_t e;
      int   errs;
      int   idx;
      if (exp_q.size() == 0) begin
         check("unexpected_frame", smp.size(), 0);
         return;
      end
      e = exp_q.pop_front();
      check("frame_len", smp.size(), 11 * e.k);
      errs = 0;
      for (int i = 0; i < smp.size(); i++) begin
         idx = i / e.k;
         if (idx < 11 && smp[i] != e.bits[idx]) errs++;
      end
      if (errs != 0)
         $display("FAIL frame_bits: %0d sample errors, expected frame %b (k=%0d)",
                  errs, e.bits, e.k);
      ntests++;
      if (errs != 0) nfail++;
      check("idle_tx", bus.TX, 1);
   endfunction

   // Monitor: collects TX while TXRDY is low, compares when it rises.
   initial begin
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            if (in_frame && exp_q.size() > 0) void'(exp_q.pop_front());
            in_frame = 1'b0;
            smp.delete();
         end else if (!in_frame) begin
            if (bus.TXRDY === 1'b0) begin
               in_frame = 1'b1;
               smp.delete();
               smp.push_back(bus.TX);
            end
         end else if (bus.TXRDY === 1'b0) begin
            smp.push_back(bus.TX);
         end else begin
            in_frame = 1'b0;
            check_frame();
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (bus.TXRDY !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) check("ready_timeout", n, 0);
   endtask

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic send(input logic [7:0] d, input bit e, input bit p, input bit o,
                       input logic [19:0] k);
      exp_t x;
      wait_ready();
      bus.OUT_PORT = d;
      bus.EIGHT    = e;
      bus.PEN      = p;
      bus.OHEL     = o;
      bus.K        = k;
      bus.LOAD     = 1'b1;
      @(posedge clk);
      x.bits = model_frame(d, e, p, o);
      x.k    = (k == 20'd0) ? 1 : int'(k);
      exp_q.push_back(x);
      @(negedge clk);
      bus.LOAD = 1'b0;
      check("accept_rdy", bus.TXRDY, 0);
      check("start_bit", bus.TX, 0);
      bus.OUT_PORT = 8'($urandom);
      bus.EIGHT    = 1'($urandom_range(0, 1));
      bus.PEN      = 1'($urandom_range(0, 1));
      bus.OHEL     = 1'($urandom_range(0, 1));
      bus.K        = 20'($urandom_range(0, 6));
   endtask

   initial begin
      int n;
      rst          = 1'b0;
      bus.LOAD     = 1'b0;
      bus.OUT_PORT = 8'h00;
      bus.EIGHT    = 1'b1;
      bus.PEN      = 1'b0;
      bus.OHEL     = 1'b0;
      bus.K        = 20'd4;
      repeat (3) @(negedge clk);
      check("reset_tx", bus.TX, 1);
      check("reset_rdy", bus.TXRDY, 1);
      rst = 1'b1;
      // Load at the first edge after reset release.
      send(8'h55, 1'b1, 1'b0, 1'b0, 20'd4);
      send(8'hA3, 1'b1, 1'b1, 1'b0, 20'd2);
      send(8'hA3, 1'b1, 1'b1, 1'b1, 20'd2);
      send(8'hC1, 1'b0, 1'b1, 1'b1, 20'd2);
      send(8'h41, 1'b0, 1'b1, 1'b1, 20'd2);
      send(8'h00, 1'b1, 1'b0, 1'b0, 20'd0);

      // Second LOAD mid-frame must be ignored.
      send(8'h0F, 1'b1, 1'b0, 1'b0, 20'd3);
      repeat (8) @(negedge clk);
      bus.OUT_PORT = 8'hF0;
      bus.LOAD     = 1'b1;
      @(negedge clk);
      bus.LOAD = 1'b0;
      check("busy_rdy", bus.TXRDY, 0);

      // LOAD held high: back-to-back frames with a one-clock ready gap.
      wait_ready();
      bus.OUT_PORT = 8'h00;
      bus.EIGHT    = 1'b1;
      bus.PEN      = 1'b0;
      bus.OHEL     = 1'b0;
      bus.K        = 20'd1;
      bus.LOAD     = 1'b1;
      for (int f = 0; f < 3; f++) begin
         exp_t x;
         wait_ready();
         @(posedge clk);
         x.bits = model_frame(8'h00, 1'b1, 1'b0, 1'b0);
         x.k    = 1;
         exp_q.push_back(x);
         @(negedge clk);
         check("b2b_accept", bus.TXRDY, 0);
      end
      bus.LOAD = 1'b0;

      // Reset mid-frame aborts immediately; next frame after release is whole.
      send(8'h96, 1'b1, 1'b1, 1'b0, 20'd8);
      repeat (18) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_tx", bus.TX, 1);
      check("abort_rdy", bus.TXRDY, 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      send(8'h3C, 1'b1, 1'b1, 1'b1, 20'd8);

      // Randomized frames with random idle gaps.
      for (int i = 0; i < 16; i++) begin
         send(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 20'($urandom_range(0, 4)));
         wait_ready();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      n = 0;
      while ((exp_q.size() != 0 || in_frame) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
